// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
//   state_t  : arbiter FSM states (exposed on dmem_arbiter.dbg_state)
//   port_t   : requester index, PORT_CACHE = port 0, PORT_FP = port 1
//   LOCK_MAX : longest run of lock-override grants to the cache before
//              the round-robin pointer is honoured again
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  typedef enum logic {
    PORT_CACHE = 1'b0,
    PORT_FP    = 1'b1
  } port_t;

  localparam int LOCK_MAX   = 4;
  localparam int LOCK_CNT_W = 3;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Winner selection for the two requesters: round-robin pointer, cache lock
// override and the consecutive-lock counter.
//   clk, rst   : clock, synchronous active-high reset
//   c_req      : cache request        f_req : FP request
//   c_lock     : cache lock request, sampled while ack_cycle is high
//   arb_en     : FSM is in IDLE; a grant is taken when win_valid is high
//   ack_cycle  : FSM is in ACK (end of the current transaction)
//   win_valid  : at least one port is requesting
//   win        : combinational winner for this cycle
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  c_req,
  input  logic  f_req,
  input  logic  c_lock,
  input  logic  arb_en,
  input  logic  ack_cycle,
  output logic  win_valid,
  output port_t win
);

  port_t                 last_port;  // port granted most recently
  logic                  lock_pend;  // cache asked to keep the memory
  logic [LOCK_CNT_W-1:0] lock_cnt;
  logic                  lock_win;

  // lock_pend is only ever high in the single IDLE cycle right after the
  // ACK in which the cache held c_lock; it clears on the following edge.
  assign lock_win  = lock_pend && c_req && (lock_cnt < LOCK_CNT_W'(LOCK_MAX));
  assign win_valid = c_req || f_req;

  always_comb begin
    win = PORT_CACHE;
    if (lock_win) begin
      win = PORT_CACHE;
    end else if (c_req && f_req) begin
      win = (last_port == PORT_CACHE) ? PORT_FP : PORT_CACHE;
    end else if (f_req) begin
      win = PORT_FP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Pretend the FP port went last so the cache wins the first tie.
      last_port <= PORT_FP;
      lock_pend <= 1'b0;
      lock_cnt  <= '0;
    end else begin
      lock_pend <= ack_cycle && c_lock && (last_port == PORT_CACHE);
      if (arb_en && win_valid) begin
        last_port <= win;
        if (win == PORT_FP) begin
          lock_cnt <= '0;
        end else if (lock_win) begin
          lock_cnt <= lock_cnt + LOCK_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: cache (port 0, with lock) and FP load/store
// (port 1) share one memory port with a fixed read latency of MEM_LAT.
//
// Handshake: a port raises *_req with we/addr/wdata valid; the request is
// taken only in IDLE, after which that port's inputs are ignored. The port
// sees exactly one *_ack pulse per granted request (writes two cycles after
// the grant, reads 2+MEM_LAT cycles after); *_rdata is valid from the read
// ack and holds until that port's next read ack. There is no back-pressure
// on ack; dropping *_req after the grant does not cancel the access.
//
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   c_req/c_we/c_addr/c_wdata/c_lock  : cache request
//   c_ack/c_rdata                     : cache completion and read data
//   f_req/f_we/f_addr/f_wdata         : FP request
//   f_ack/f_rdata                     : FP completion and read data
//   mem_en/mem_we/mem_addr/mem_wdata  : memory strobe (one cycle) and request
//   mem_rdata                         : memory read data, MEM_LAT after mem_en
//   gnt                               : one-hot owner, 00 in IDLE
//   busy                              : FSM not in IDLE
//   dbg_state                         : current FSM state
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  input  logic              c_lock,
  output logic              c_ack,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              f_req,
  input  logic              f_we,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic [DATA_W-1:0] f_wdata,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        gnt,
  output logic              busy,
  output state_t            dbg_state
);

  // wait_cnt runs 0..MEM_LAT-1, so it tops out at 14 and never wraps.
  localparam logic [3:0] LAST_WAIT = 4'(MEM_LAT - 1);

  state_t     state;
  logic [3:0] wait_cnt;
  logic       win_valid;
  port_t      win;

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst       (rst),
    .c_req     (c_req),
    .f_req     (f_req),
    .c_lock    (c_lock),
    .arb_en    (state == ST_IDLE),
    .ack_cycle (state == ST_ACK),
    .win_valid (win_valid),
    .win       (win)
  );

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  // mem_addr/mem_wdata double as the request latch: they are loaded at the
  // grant and held until the next grant. mem_we is the latched write flag
  // while in ISSUE, which is where the read/write branch is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      c_ack     <= 1'b0;
      f_ack     <= 1'b0;
      c_rdata   <= '0;
      f_rdata   <= '0;
      gnt       <= 2'b00;
    end else begin
      c_ack <= 1'b0;
      f_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            state  <= ST_ISSUE;
            mem_en <= 1'b1;
            if (win == PORT_FP) begin
              gnt       <= 2'b10;
              mem_we    <= f_we;
              mem_addr  <= f_addr;
              mem_wdata <= f_wdata;
            end else begin
              gnt       <= 2'b01;
              mem_we    <= c_we;
              mem_addr  <= c_addr;
              mem_wdata <= c_wdata;
            end
          end
        end
        ST_ISSUE: begin
          mem_en   <= 1'b0;
          mem_we   <= 1'b0;
          wait_cnt <= '0;
          if (mem_we) begin
            state <= ST_ACK;
            c_ack <= gnt[0];
            f_ack <= gnt[1];
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == LAST_WAIT) begin
            state    <= ST_ACK;
            wait_cnt <= '0;
            c_ack    <= gnt[0];
            f_ack    <= gnt[1];
            if (gnt[1]) begin
              f_rdata <= mem_rdata;
            end else begin
              c_rdata <= mem_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ST_ACK: begin
          state <= ST_IDLE;
          gnt   <= 2'b00;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter. Two instances share every input: index 0 has
// MEM_LAT=1, index 1 has MEM_LAT=15. A transaction-level model per instance
// (grant time plus cycle offsets) predicts every output and is compared on
// each falling edge; directed literal checks pin the key timings.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          c_req = 1'b0, c_we = 1'b0, c_lock = 1'b0;
  logic          f_req = 1'b0, f_we = 1'b0;
  logic [AW-1:0] c_addr = '0, f_addr = '0;
  logic [DW-1:0] c_wdata = '0, f_wdata = '0, mem_rdata = '0;

  logic          c_ack_w     [2];
  logic          f_ack_w     [2];
  logic [DW-1:0] c_rdata_w   [2];
  logic [DW-1:0] f_rdata_w   [2];
  logic          mem_en_w    [2];
  logic          mem_we_w    [2];
  logic [AW-1:0] mem_addr_w  [2];
  logic [DW-1:0] mem_wdata_w [2];
  logic [1:0]    gnt_w       [2];
  logic          busy_w      [2];
  state_t        st_w        [2];

  int            errors = 0;
  int            checks = 0;
  logic          rd_mode = 1'b0;
  logic [15:0]   rd_cnt = '0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut_l1 (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_lock(c_lock),
    .c_ack(c_ack_w[0]), .c_rdata(c_rdata_w[0]),
    .f_req(f_req), .f_we(f_we), .f_addr(f_addr), .f_wdata(f_wdata),
    .f_ack(f_ack_w[0]), .f_rdata(f_rdata_w[0]),
    .mem_en(mem_en_w[0]), .mem_we(mem_we_w[0]), .mem_addr(mem_addr_w[0]),
    .mem_wdata(mem_wdata_w[0]), .mem_rdata(mem_rdata),
    .gnt(gnt_w[0]), .busy(busy_w[0]), .dbg_state(st_w[0])
  );

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(15)) dut_l15 (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_lock(c_lock),
    .c_ack(c_ack_w[1]), .c_rdata(c_rdata_w[1]),
    .f_req(f_req), .f_we(f_we), .f_addr(f_addr), .f_wdata(f_wdata),
    .f_ack(f_ack_w[1]), .f_rdata(f_rdata_w[1]),
    .mem_en(mem_en_w[1]), .mem_we(mem_we_w[1]), .mem_addr(mem_addr_w[1]),
    .mem_wdata(mem_wdata_w[1]), .mem_rdata(mem_rdata),
    .gnt(gnt_w[1]), .busy(busy_w[1]), .dbg_state(st_w[1])
  );

  // ---------------- check / clocking helpers ----------------
  task automatic check(input string name, input int d,
                       input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h required %0h", name, d, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rd_mode) begin
      rd_cnt++;
      mem_rdata = {16'hC0DE, rd_cnt};
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 15;
  endfunction

  // ---------------- transaction-level model ----------------
  // A granted transaction is described by its owner, we/addr/wdata and the
  // number of edges n since the grant edge: mem_en after n=0, ack after
  // n=1 (write) or n=1+MEM_LAT (read), back to idle one edge later.
  logic          m_valid = 1'b0;
  logic          m_act     [2];
  int            m_n       [2];
  logic          m_own     [2];
  logic          m_we      [2];
  logic [AW-1:0] m_addr    [2];
  logic [DW-1:0] m_wdata   [2];
  logic          m_last    [2];
  logic          m_lpend   [2];
  int            m_lcnt    [2];
  logic [DW-1:0] m_crd     [2];
  logic [DW-1:0] m_frd     [2];
  logic          m_rstseen [2];

  task automatic model_step(input int d);
    int  ackn;
    logic w;
    if (rst) begin
      m_act[d] = 1'b0; m_n[d] = 0; m_own[d] = 1'b0; m_we[d] = 1'b0;
      m_last[d] = 1'b1; m_lpend[d] = 1'b0; m_lcnt[d] = 0;
      m_crd[d] = '0; m_frd[d] = '0; m_addr[d] = '0; m_wdata[d] = '0;
      m_rstseen[d] = 1'b1;
      m_valid = 1'b1;
      return;
    end
    m_rstseen[d] = 1'b0;
    if (m_act[d]) begin
      ackn = m_we[d] ? 1 : 1 + lat(d);
      m_n[d] = m_n[d] + 1;
      if (m_n[d] == ackn && !m_we[d]) begin
        if (m_own[d]) m_frd[d] = mem_rdata;
        else          m_crd[d] = mem_rdata;
      end
      if (m_n[d] == ackn + 1) begin
        m_act[d]   = 1'b0;
        m_lpend[d] = !m_own[d] && c_lock;
      end
    end else begin
      if (c_req || f_req) begin
        if (m_lpend[d] && c_req && m_lcnt[d] < LOCK_MAX) begin
          w = 1'b0;
          m_lcnt[d] = m_lcnt[d] + 1;
        end else if (c_req && f_req) begin
          w = !m_last[d];
        end else begin
          w = f_req;
        end
        if (w) m_lcnt[d] = 0;
        m_last[d]  = w;
        m_own[d]   = w;
        m_act[d]   = 1'b1;
        m_n[d]     = 0;
        m_we[d]    = w ? f_we : c_we;
        m_addr[d]  = w ? f_addr : c_addr;
        m_wdata[d] = w ? f_wdata : c_wdata;
      end
      m_lpend[d] = 1'b0;
    end
  endtask

  task automatic compare_dut(input int d);
    int   ackn;
    logic en_e;
    ackn = m_we[d] ? 1 : 1 + lat(d);
    en_e = m_act[d] && (m_n[d] == 0);
    check("busy", d, 64'(busy_w[d]), 64'(m_act[d]));
    check("state_idle", d, 64'(st_w[d] == ST_IDLE), 64'(!m_act[d]));
    check("gnt", d, 64'(gnt_w[d]),
          64'(m_act[d] ? (m_own[d] ? 2'b10 : 2'b01) : 2'b00));
    check("mem_en", d, 64'(mem_en_w[d]), 64'(en_e));
    check("mem_we", d, 64'(mem_we_w[d]), 64'(en_e && m_we[d]));
    if (en_e || m_rstseen[d]) begin
      check("mem_addr", d, 64'(mem_addr_w[d]), 64'(m_addr[d]));
      check("mem_wdata", d, 64'(mem_wdata_w[d]), 64'(m_wdata[d]));
    end
    check("c_ack", d, 64'(c_ack_w[d]),
          64'(m_act[d] && m_n[d] == ackn && !m_own[d]));
    check("f_ack", d, 64'(f_ack_w[d]),
          64'(m_act[d] && m_n[d] == ackn && m_own[d]));
    check("c_rdata", d, 64'(c_rdata_w[d]), 64'(m_crd[d]));
    check("f_rdata", d, 64'(f_rdata_w[d]), 64'(m_frd[d]));
  endtask

  // Compare the state reached at the last rising edge, then advance the
  // model with the inputs the DUT will sample at the next rising edge.
  always @(negedge clk) begin
    if (m_valid) begin
      for (int d = 0; d < 2; d++) compare_dut(d);
    end
    for (int d = 0; d < 2; d++) model_step(d);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      check("rst_busy", d, 64'(busy_w[d]), 64'(0));
      check("rst_gnt", d, 64'(gnt_w[d]), 64'(0));
      check("rst_mem_en", d, 64'(mem_en_w[d]), 64'(0));
      check("rst_mem_addr", d, 64'(mem_addr_w[d]), 64'(0));
      check("rst_c_rdata", d, 64'(c_rdata_w[d]), 64'(0));
      check("rst_f_rdata", d, 64'(f_rdata_w[d]), 64'(0));
    end

    // Single cache read at 0x40, memory returns 0xDEADBEEF.
    rst = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h40;
    tick();                                        // t+1
    check("rd_mem_en_t1", 0, 64'(mem_en_w[0]), 64'(1));
    check("rd_mem_addr_t1", 0, 64'(mem_addr_w[0]), 64'h40);
    c_req = 1'b0;
    mem_rdata = 32'hDEADBEEF;
    tick();                                        // t+2
    check("rd_c_ack_t2", 0, 64'(c_ack_w[0]), 64'(0));
    tick();                                        // t+3
    check("rd_c_ack_t3", 0, 64'(c_ack_w[0]), 64'(1));
    check("rd_c_rdata_t3", 0, 64'(c_rdata_w[0]), 64'hDEADBEEF);
    check("rd_f_ack_t3", 0, 64'(f_ack_w[0]), 64'(0));
    idle(20);
    check("rd_c_rdata_l15", 1, 64'(c_rdata_w[1]), 64'hDEADBEEF);

    // Both ports writing continuously from reset: cache, FP, cache, FP.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h100; c_wdata = 32'h1111_1111;
    f_req = 1'b1; f_we = 1'b1; f_addr = 32'h200; f_wdata = 32'h2222_2222;
    for (int i = 0; i < 4; i++) begin
      tick();                                      // t+1+3i
      check("rr_gnt", 0, 64'(gnt_w[0]), 64'((i % 2 == 0) ? 2'b01 : 2'b10));
      check("rr_gnt", 1, 64'(gnt_w[1]), 64'((i % 2 == 0) ? 2'b01 : 2'b10));
      tick();                                      // t+2+3i
      check("rr_ack", 0, 64'({f_ack_w[0], c_ack_w[0]}),
            64'((i % 2 == 0) ? 2'b01 : 2'b10));
      tick();                                      // t+3+3i (IDLE)
    end
    c_req = 1'b0; f_req = 1'b0;
    idle(3);

    // Cache lock held with both requesting: five cache grants, then FP.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    c_lock = 1'b1;
    c_req = 1'b1; f_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("lock_gnt", 0, 64'(gnt_w[0]), 64'((i < 5) ? 2'b01 : 2'b10));
      tick();
      tick();
    end
    c_req = 1'b0; f_req = 1'b0; c_lock = 1'b0;
    idle(3);

    // FP read on the 15-cycle instance; f_addr changes during WAIT.
    f_req = 1'b1; f_we = 1'b0; f_addr = 32'h1234;
    rd_mode = 1'b1;
    tick();                                        // t+1
    check("lat15_mem_en", 1, 64'(mem_en_w[1]), 64'(1));
    check("lat15_mem_addr", 1, 64'(mem_addr_w[1]), 64'h1234);
    f_req = 1'b0;
    tick();                                        // t+2
    f_addr = 32'h80;
    for (int k = 3; k <= 16; k++) begin
      tick();
      check("lat15_f_ack_early", 1, 64'(f_ack_w[1]), 64'(0));
      check("lat15_addr_hold", 1, 64'(mem_addr_w[1]), 64'h1234);
    end
    tick();                                        // t+17
    check("lat15_f_ack_t17", 1, 64'(f_ack_w[1]), 64'(1));
    rd_mode = 1'b0;
    idle(3);

    // Reset during WAIT of a cache read on the 15-cycle instance.
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h300;
    mem_rdata = 32'h0BAD_F00D;
    tick();
    c_req = 1'b0;
    idle(4);                                       // t+5, instance 1 in WAIT
    check("mid_busy", 1, 64'(busy_w[1]), 64'(1));
    rst = 1'b1;
    tick();
    check("mid_rst_c_ack", 1, 64'(c_ack_w[1]), 64'(0));
    check("mid_rst_busy", 1, 64'(busy_w[1]), 64'(0));
    check("mid_rst_gnt", 1, 64'(gnt_w[1]), 64'(0));
    check("mid_rst_addr", 1, 64'(mem_addr_w[1]), 64'(0));
    check("mid_rst_c_rdata", 0, 64'(c_rdata_w[0]), 64'(0));
    rst = 1'b0;
    c_req = 1'b1; f_req = 1'b1; c_we = 1'b1; f_we = 1'b1;
    tick();
    check("post_rst_tie", 0, 64'(gnt_w[0]), 64'(2'b01));
    check("post_rst_tie", 1, 64'(gnt_w[1]), 64'(2'b01));
    c_req = 1'b0; f_req = 1'b0;
    idle(4);

    // FP read whose request drops right after the grant.
    f_req = 1'b1; f_we = 1'b0; f_addr = 32'h44;
    mem_rdata = 32'h1357_9BDF;
    tick();                                        // t+1
    check("drop_mem_en", 0, 64'(mem_en_w[0]), 64'(1));
    check("drop_gnt", 0, 64'(gnt_w[0]), 64'(2'b10));
    f_req = 1'b0;
    tick();
    tick();                                        // t+3
    check("drop_f_ack", 0, 64'(f_ack_w[0]), 64'(1));
    check("drop_f_rdata", 0, 64'(f_rdata_w[0]), 64'h1357_9BDF);
    check("drop_c_rdata", 0, 64'(c_rdata_w[0]), 64'(0));
    idle(20);
    check("drop_f_rdata", 1, 64'(f_rdata_w[1]), 64'h1357_9BDF);

    // Mixed traffic: overlapping reads/writes, lock toggling, changing data.
    rd_mode = 1'b1;
    for (int i = 0; i < 60; i++) begin
      c_req   = (i % 3 != 0);
      f_req   = (i % 2 == 0);
      c_we    = (i % 4 == 1);
      f_we    = (i % 5 == 2);
      c_lock  = (i % 7 < 3);
      c_addr  = 32'h1000 + 32'(i);
      f_addr  = 32'h2000 + 32'(i);
      c_wdata = 32'hA000_0000 + 32'(i);
      f_wdata = 32'hB000_0000 + 32'(i);
      tick();
    end
    c_req = 1'b0; f_req = 1'b0; c_lock = 1'b0;
    idle(20);
    rd_mode = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
